// File: rtl/fir_coeff_ctrl.sv
// Run-time coefficient controller for the 9-tap FIR.
// Holds a shadow coefficient bank loaded one tap at a time through the config
// port, swaps it into the active bank at a sample gap (or after a bounded
// wait), and masks the FIR output strobe while mixed-coefficient results drain.
module fir_coeff_ctrl #(
  parameter int NTAPS    = 9,
  parameter int CW       = 16,
  parameter int PIPE_LAT = 6,
  parameter int MAX_WAIT = 16,
  parameter logic [NTAPS*CW-1:0] DEFAULT_COEFF = {
    16'h04F6, 16'h0AE4, 16'h1089, 16'h1496, 16'h160F,
    16'h1496, 16'h1089, 16'h0AE4, 16'h04F6
  }
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                in_valid,
  input  logic                cfg_wr_en,
  input  logic [3:0]          cfg_wr_addr,
  input  logic [CW-1:0]       cfg_wr_data,
  input  logic                cfg_commit,
  output logic [NTAPS*CW-1:0] coeff_flat,
  output logic                coeff_swap,
  output logic                out_valid,
  output logic                cfg_busy,
  output logic                cfg_err
);

  localparam int WCW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam int FCW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_FLUSH
  } state_t;

  state_t              state_q;
  logic [CW-1:0]       shadow_q [NTAPS];
  logic [CW-1:0]       active_q [NTAPS];
  logic [PIPE_LAT-1:0] vpipe_q;
  logic [PIPE_LAT-1:0] vpipe_d;
  logic [WCW-1:0]      wait_cnt_q;
  logic [FCW-1:0]      flush_cnt_q;
  logic                swap_q;
  logic                err_q;
  logic                err_d;

  logic busy;
  logic addr_bad;
  logic wr_ok;
  logic commit_ok;
  logic swap_now;

  // Request decode: a rejected cycle applies neither its write nor its commit.
  always_comb begin
    busy      = (state_q != S_IDLE);
    addr_bad  = cfg_wr_en && (cfg_wr_addr >= 4'(NTAPS));
    err_d     = (cfg_wr_en && busy) || (cfg_commit && busy) || addr_bad;
    wr_ok     = cfg_wr_en && !err_d;
    commit_ok = cfg_commit && !err_d;
    swap_now  = (state_q == S_ARMED) &&
                (!in_valid || (wait_cnt_q == WCW'(MAX_WAIT - 1)));
    // Valid pipe is emptied on the swap edge so mixed-bank results are never flagged.
    vpipe_d   = swap_now ? '0 : {vpipe_q[PIPE_LAT-2:0], in_valid};
  end

  // Bank storage, valid pipe and commit/flush sequencing.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= S_IDLE;
      vpipe_q     <= '0;
      wait_cnt_q  <= '0;
      flush_cnt_q <= '0;
      swap_q      <= 1'b0;
      err_q       <= 1'b0;
      for (int unsigned k = 0; k < NTAPS; k++) begin
        shadow_q[k] <= DEFAULT_COEFF[k*CW +: CW];
        active_q[k] <= DEFAULT_COEFF[k*CW +: CW];
      end
    end else begin
      err_q   <= err_d;
      swap_q  <= swap_now;
      vpipe_q <= vpipe_d;
      if (wr_ok) begin
        shadow_q[cfg_wr_addr] <= cfg_wr_data;
      end
      case (state_q)
        S_IDLE: begin
          if (commit_ok) begin
            state_q    <= S_ARMED;
            wait_cnt_q <= '0;
          end
        end
        S_ARMED: begin
          if (swap_now) begin
            for (int unsigned k = 0; k < NTAPS; k++) begin
              active_q[k] <= shadow_q[k];
            end
            flush_cnt_q <= FCW'(PIPE_LAT - 1);
            state_q     <= S_FLUSH;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end
        S_FLUSH: begin
          if (flush_cnt_q == '0) begin
            state_q <= S_IDLE;
          end else begin
            flush_cnt_q <= flush_cnt_q - 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Flatten the active bank onto the FIR coefficient bus.
  always_comb begin
    coeff_flat = '0;
    for (int unsigned k = 0; k < NTAPS; k++) begin
      coeff_flat[k*CW +: CW] = active_q[k];
    end
  end

  assign coeff_swap = swap_q;
  assign cfg_err    = err_q;
  assign cfg_busy   = busy;
  assign out_valid  = vpipe_q[PIPE_LAT-1] && (state_q != S_FLUSH);

endmodule

// File: tb/tb_fir_coeff_ctrl.sv
// Directed bench for fir_coeff_ctrl: a cycle table for commit/reject behaviour
// plus hand sequences for reset streaming, forced swap and reset during flush.
module tb_fir_coeff_ctrl;

  localparam int NTAPS    = 9;
  localparam int CW       = 16;
  localparam int PIPE_LAT = 6;
  localparam int MAX_WAIT = 16;
  localparam logic [NTAPS*CW-1:0] DEF = {
    16'h04F6, 16'h0AE4, 16'h1089, 16'h1496, 16'h160F,
    16'h1496, 16'h1089, 16'h0AE4, 16'h04F6
  };

  logic                CLK = 1'b0;
  logic                RST_N;
  logic                in_valid;
  logic                cfg_wr_en;
  logic [3:0]          cfg_wr_addr;
  logic [CW-1:0]       cfg_wr_data;
  logic                cfg_commit;
  logic [NTAPS*CW-1:0] coeff_flat;
  logic                coeff_swap;
  logic                out_valid;
  logic                cfg_busy;
  logic                cfg_err;

  fir_coeff_ctrl #(
    .NTAPS(NTAPS),
    .CW(CW),
    .PIPE_LAT(PIPE_LAT),
    .MAX_WAIT(MAX_WAIT),
    .DEFAULT_COEFF(DEF)
  ) dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .in_valid(in_valid),
    .cfg_wr_en(cfg_wr_en),
    .cfg_wr_addr(cfg_wr_addr),
    .cfg_wr_data(cfg_wr_data),
    .cfg_commit(cfg_commit),
    .coeff_flat(coeff_flat),
    .coeff_swap(coeff_swap),
    .out_valid(out_valid),
    .cfg_busy(cfg_busy),
    .cfg_err(cfg_err)
  );

  always #5 CLK = ~CLK;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic        iv;
    logic        we;
    logic [3:0]  wa;
    logic [15:0] wd;
    logic        cm;
    logic        e_swap;
    logic        e_valid;
    logic        e_busy;
    logic        e_err;
    int          tidx;
    logic [15:0] tval;
  } vec_t;

  vec_t tbl [23];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic chk_flat(input string name);
    n_total++;
    if (coeff_flat === DEF) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, coeff_flat, DEF);
  endtask

  function automatic logic [CW-1:0] tap(input int k);
    logic [NTAPS*CW-1:0] f;
    f = coeff_flat;
    return f[k*CW +: CW];
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clr_in();
    in_valid    = 1'b0;
    cfg_wr_en   = 1'b0;
    cfg_wr_addr = '0;
    cfg_wr_data = '0;
    cfg_commit  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int k;
    // Rows: iv, we, wa, wd, cm | swap, valid, busy, err, tap idx, tap value
    tbl[0]  = '{1'b1, 1'b1, 4'd4,  16'h2000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4, 16'h160F};
    tbl[1]  = '{1'b1, 1'b0, 4'd0,  16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4, 16'h160F};
    tbl[2]  = '{1'b1, 1'b0, 4'd0,  16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4, 16'h160F};
    tbl[3]  = '{1'b0, 1'b0, 4'd0,  16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4, 16'h160F};
    tbl[4]  = '{1'b1, 1'b1, 4'd4,  16'h1234, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4, 16'h2000};
    tbl[5]  = '{1'b1, 1'b0, 4'd0,  16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4, 16'h2000};
    tbl[6]  = '{1'b1, 1'b0, 4'd0,  16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 16'h04F6};
    tbl[7]  = '{1'b1, 1'b0, 4'd0,  16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4, 16'h2000};
    tbl[8]  = '{1'b1, 1'b0, 4'd0,  16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8, 16'h04F6};
    tbl[9]  = '{1'b1, 1'b0, 4'd0,  16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4, 16'h2000};
    tbl[10] = '{1'b0, 1'b1, 4'd9,  16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4, 16'h2000};
    tbl[11] = '{1'b0, 1'b1, 4'd0,  16'h7FFF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 0, 16'h04F6};
    tbl[12] = '{1'b0, 1'b0, 4'd0,  16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 16'h04F6};
    tbl[13] = '{1'b0, 1'b0, 4'd0,  16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0, 16'h7FFF};
    tbl[14] = '{1'b0, 1'b0, 4'd0,  16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4, 16'h2000};
    tbl[15] = '{1'b0, 1'b0, 4'd0,  16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1, 16'h0AE4};
    tbl[16] = '{1'b0, 1'b0, 4'd0,  16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3, 16'h1496};
    tbl[17] = '{1'b0, 1'b0, 4'd0,  16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5, 16'h1496};
    tbl[18] = '{1'b0, 1'b0, 4'd0,  16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 7, 16'h0AE4};
    tbl[19] = '{1'b0, 1'b1, 4'd10, 16'hAAAA, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4, 16'h2000};
    tbl[20] = '{1'b0, 1'b1, 4'd15, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 16'h7FFF};
    tbl[21] = '{1'b0, 1'b0, 4'd0,  16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2, 16'h1089};
    tbl[22] = '{1'b0, 1'b0, 4'd0,  16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4, 16'h2000};

    // Reset values, then a steady stream from cycle 0.
    clr_in();
    RST_N = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk_flat("rst_coeff");
    chk("rst_swap", coeff_swap, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", cfg_busy, 0);
    chk("rst_err", cfg_err, 0);
    RST_N    = 1'b1;
    in_valid = 1'b1;
    chk_flat("stream_coeff");
    for (int c = 0; c <= PIPE_LAT; c++) begin
      chk($sformatf("stream_valid_c%0d", c), out_valid, (c >= PIPE_LAT) ? 1 : 0);
      tick();
    end

    // Table run from a fresh reset.
    clr_in();
    RST_N = 1'b0;
    tick();
    RST_N = 1'b1;
    for (int i = 0; i < 23; i++) begin
      chk($sformatf("row%0d_swap", i), coeff_swap, tbl[i].e_swap);
      chk($sformatf("row%0d_valid", i), out_valid, tbl[i].e_valid);
      chk($sformatf("row%0d_busy", i), cfg_busy, tbl[i].e_busy);
      chk($sformatf("row%0d_err", i), cfg_err, tbl[i].e_err);
      chk($sformatf("row%0d_tap%0d", i, tbl[i].tidx), tap(tbl[i].tidx), tbl[i].tval);
      in_valid    = tbl[i].iv;
      cfg_wr_en   = tbl[i].we;
      cfg_wr_addr = tbl[i].wa;
      cfg_wr_data = tbl[i].wd;
      cfg_commit  = tbl[i].cm;
      tick();
    end

    // Forced swap under a continuous stream.
    clr_in();
    in_valid   = 1'b1;
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    chk("forced_busy", cfg_busy, 1);
    k = 1;
    while (!coeff_swap && k < 40) begin
      tick();
      k++;
    end
    chk("forced_swap_latency", k, MAX_WAIT + 1);
    for (int j = 0; j < PIPE_LAT; j++) begin
      chk($sformatf("forced_mask_%0d", j), out_valid, 0);
      tick();
      if (j == 0) chk("forced_single_swap", coeff_swap, 0);
    end
    chk("forced_valid_back", out_valid, 1);
    chk("forced_idle", cfg_busy, 0);

    // Reset two cycles into FLUSH.
    clr_in();
    cfg_wr_en   = 1'b1;
    cfg_wr_addr = 4'd2;
    cfg_wr_data = 16'h1111;
    tick();
    clr_in();
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    tick();
    chk("flushrst_swap", coeff_swap, 1);
    chk("flushrst_tap2", tap(2), 16'h1111);
    tick();
    tick();
    #2;
    RST_N = 1'b0;
    #1;
    chk_flat("flushrst_coeff");
    chk("flushrst_busy", cfg_busy, 0);
    chk("flushrst_swap0", coeff_swap, 0);
    chk("flushrst_valid", out_valid, 0);
    chk("flushrst_err", cfg_err, 0);

    // Commit with no prior writes re-swaps the (defaulted) shadow and still flushes.
    @(posedge CLK);
    #1;
    RST_N      = 1'b1;
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    tick();
    chk("reswap_pulse", coeff_swap, 1);
    chk("reswap_tap2", tap(2), 16'h1089);
    chk("reswap_busy", cfg_busy, 1);
    repeat (PIPE_LAT) tick();
    chk("reswap_idle", cfg_busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
